fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core. Sits directly around the PC register:
- consumes the registered PC;
- computes the next PC and drives it back into the PC register;
- issues one-outstanding requests to instruction memory over a valid/ready handshake;
- delivers fetched instructions into the IF/ID pipeline register;
- handles decode stalls (one-entry hold buffer) and branch/jump redirects (flush and discard of in-flight responses).

## Interface
Parameters:
- XLEN, 64, address/PC width
- ILEN, 32, instruction width
- RESET_PC, 64'h0, PC value driven to the PC register while reset is asserted

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_in  in  XLEN  current PC from the PC register output
- pc_next  out  XLEN  next PC, drives PC register input (register loads every cycle)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  response valid (never before the cycle after acceptance)
- imem_rsp_data  in  ILEN  fetched instruction
- stall  in  1  hazard unit: hold IF/ID contents
- redirect_valid  in  1  branch/jump taken: flush and redirect
- redirect_pc  in  XLEN  redirect target; bits [1:0] forced to 0
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_pc  out  XLEN  PC of IF/ID instruction
- ifid_instr  out  ILEN  IF/ID instruction

## Operation
- FSM states: IDLE (nothing outstanding), WAIT (request accepted, response pending), DROP (response pending, to be discarded), HOLD (response captured in hold buffer while stalled).
- imem_req_addr = pc_in always.
- imem_req_valid = 1 when all of:
  - not rst and not redirect_valid;
  - state is IDLE, or state is WAIT with imem_rsp_valid and that response written to IF/ID this cycle.
- Acceptance = imem_req_valid & imem_req_ready. On acceptance, req_pc <= pc_in and state <= WAIT.
- pc_next priority:
  - rst → RESET_PC;
  - redirect_valid → {redirect_pc[XLEN-1:2], 2'b00};
  - acceptance → pc_in + 4, modulo 2^XLEN (wraps from all-ones region to 0);
  - otherwise → pc_in.
- pc_in is held stable while valid & !ready.
- WAIT transitions:
  - rsp_valid & redirect_valid → discard response, IDLE;
  - rsp_valid & !stall → IF/ID <= {1, req_pc, rsp_data}, then WAIT if a new request is accepted the same cycle, else IDLE;
  - rsp_valid & stall → hold buffer <= {req_pc, rsp_data}, HOLD;
  - no response & redirect_valid → DROP.
- DROP: on rsp_valid, discard and go to IDLE. No new request is issued while in DROP.
- HOLD transitions:
  - redirect_valid → discard buffer, IDLE;
  - !stall → IF/ID <= buffer, IDLE.
- IF/ID update priority:
  - redirect_valid → ifid_valid <= 0 (flush beats stall);
  - else stall → hold all fields;
  - else new instruction written if available, otherwise ifid_valid <= 0 (bubble).
- ifid_pc and ifid_instr keep their previous values when a bubble is inserted.

## Timing
- Reset values (registered, effective the cycle after rst is sampled high):
  - state IDLE;
  - ifid_valid 0, ifid_pc 0, ifid_instr 32'h00000013 (NOP);
  - req_pc 0, hold buffer 0.
- Reset outputs (combinational while rst high): imem_req_valid 0, pc_next = RESET_PC.
- rst mid-operation abandons any outstanding request. A response arriving after reset deasserts while in IDLE is ignored.
- Fetch latency: acceptance in cycle N, response in cycle N+k (k ≥ 1), ifid_valid = 1 in cycle N+k+1.
- Throughput: one instruction per cycle with k = 1 and continuous ready.
- At most one request outstanding. rsp_valid in IDLE or HOLD is a protocol error and is ignored.

## Structure
- Shared package fetch_pkg holds:
  - fetch_state_t enum (IDLE, WAIT, DROP, HOLD);
  - NOP_INSTR = 32'h00000013;
  - ILEN;
  - INSTR_BYTES = 4.
- One sub-module: ifid_reg, the IF/ID register with stall/flush/bubble priority and reset to NOP. The FSM, hold buffer and next-PC mux stay in fetch_unit.

## Test plan
- Reset, then ready = 1 and 1-cycle memory from pc 0 → pc_next sequence 4, 8, 12; ifid_pc 0, 4, 8 on consecutive cycles with ifid_valid = 1 from cycle 3.
- ready = 0 for 3 cycles at pc 0x100 → imem_req_addr stays 0x100, pc_next = 0x100, ifid_valid = 0; accepted on cycle 4.
- Response arrives while stall = 1 → HOLD; IF/ID unchanged. Stall released 2 cycles later → ifid_pc = req_pc next cycle, then IDLE.
- redirect_valid with target 0x2002 while WAIT → DROP; the next response is discarded, ifid_valid = 0, and the next request address is 0x2000.
- redirect_valid and stall in the same cycle → ifid_valid = 0 next cycle.
- pc_in = 64'hFFFF_FFFF_FFFF_FFFC accepted → pc_next = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned ILEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats write, otherwise a bubble.
module ifid_reg #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            wr_valid,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [ILEN-1:0] wr_instr,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [ILEN-1:0] ifid_instr
);
    import fetch_pkg::*;

    logic            valid_d, valid_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [ILEN-1:0] instr_d, instr_q;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            if (wr_valid) begin
                valid_d = 1'b1;
                pc_d    = wr_pc;
                instr_d = wr_instr;
            end else begin
                // bubble: payload fields keep their old contents
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= ILEN'(NOP_INSTR);
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign ifid_valid = valid_q;
    assign ifid_pc    = pc_q;
    assign ifid_instr = instr_q;

endmodule : ifid_reg

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC mux, one-outstanding imem request FSM,
// stall hold buffer and redirect flush around the external PC register.
module fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [ILEN-1:0] ifid_instr
);
    import fetch_pkg::*;

    fetch_state_t    state_d, state_q;
    logic [XLEN-1:0] req_pc_d, req_pc_q;
    logic [XLEN-1:0] hold_pc_d, hold_pc_q;
    logic [ILEN-1:0] hold_instr_d, hold_instr_q;

    logic            rsp_to_ifid;
    logic            accept;
    logic            wr_valid;
    logic [XLEN-1:0] wr_pc;
    logic [ILEN-1:0] wr_instr;
    logic [XLEN-1:0] redirect_tgt;

    assign imem_req_addr = pc_in;
    assign redirect_tgt  = redirect_pc & ~XLEN'(INSTR_BYTES - 1);

    // Next-state, request handshake and IF/ID write selection
    always_comb begin
        state_d        = state_q;
        req_pc_d       = req_pc_q;
        hold_pc_d      = hold_pc_q;
        hold_instr_d   = hold_instr_q;
        wr_valid       = 1'b0;
        wr_pc          = req_pc_q;
        wr_instr       = imem_rsp_data;

        rsp_to_ifid    = (state_q == WAIT) && imem_rsp_valid && !redirect_valid && !stall;
        imem_req_valid = !rst && !redirect_valid && ((state_q == IDLE) || rsp_to_ifid);
        accept         = imem_req_valid && imem_req_ready;

        unique case (state_q)
            IDLE: ;
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid) begin
                        state_d = IDLE;
                    end else if (!stall) begin
                        wr_valid = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        hold_pc_d    = req_pc_q;
                        hold_instr_d = imem_rsp_data;
                        state_d      = HOLD;
                    end
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    wr_valid = 1'b1;
                    wr_pc    = hold_pc_q;
                    wr_instr = hold_instr_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // back-to-back issue keeps the FSM in WAIT
        if (accept) begin
            req_pc_d = pc_in;
            state_d  = WAIT;
        end
    end

    always_comb begin
        pc_next = pc_in;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (redirect_valid) begin
            pc_next = redirect_tgt;
        end else if (accept) begin
            pc_next = pc_in + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_pc_q     <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    ifid_reg #(
        .XLEN(XLEN),
        .ILEN(ILEN)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .stall     (stall),
        .wr_valid  (wr_valid),
        .wr_pc     (wr_pc),
        .wr_instr  (wr_instr),
        .ifid_valid(ifid_valid),
        .ifid_pc   (ifid_pc),
        .ifid_instr(ifid_instr)
    );

endmodule : fetch_unit
